watch_time_counter: RTL and testbench

- Consumes the 100 Hz single-cycle tick from the tick generator and keeps watch time as centiseconds, seconds, minutes and hours.
- Provides run/stop, clear, parallel load (from the UART command decoder) and per-field increment pulses (from debounced buttons).
- Registered time fields feed the FND/display formatter and the UART status reporter.

---
 rtl/watch_time_counter.sv | 152 +++++++++++++++
 tb/tb_watch_time_counter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_time_counter.sv
// watch_time_counter
// Keeps watch time as centiseconds, seconds, minutes and hours, advanced by
// a single-cycle tick at TICK_FREQ. Supports run/stop, clear, parallel load
// with range checking, and per-field increment pulses.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-low reset
//   i_tick       1-cycle tick pulse at TICK_FREQ
//   i_run        level, 1 = count ticks, 0 = hold
//   i_clear      1-cycle pulse, return to INIT_HOUR:00:00.00
//   i_load       1-cycle pulse, load i_set_hour/min/sec (csec -> 0)
//   i_set_hour   hour load value (values > 23 load 0)
//   i_set_min    minute load value (values > 59 load 0)
//   i_set_sec    second load value (values > 59 load 0)
//   i_inc_hour   1-cycle pulse, hour + 1 with wrap
//   i_inc_min    1-cycle pulse, minute + 1 with wrap (no carry into hour)
//   o_csec       centiseconds 0..TICK_FREQ-1
//   o_sec        seconds 0..59
//   o_min        minutes 0..59
//   o_hour       hours 0..23
//   o_sec_pulse  1-cycle pulse when a tick carries into seconds
//   o_day_pulse  1-cycle pulse when a tick carry wraps hours 23 -> 0
//   o_load_err   1-cycle pulse when a load had an out-of-range field
module watch_time_counter #(
    parameter int TICK_FREQ = 100,
    parameter int INIT_HOUR = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tick,
    input  logic       i_run,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [4:0] i_set_hour,
    input  logic [5:0] i_set_min,
    input  logic [5:0] i_set_sec,
    input  logic       i_inc_hour,
    input  logic       i_inc_min,
    output logic [6:0] o_csec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_sec_pulse,
    output logic       o_day_pulse,
    output logic       o_load_err
);

    localparam logic [6:0] CSEC_LAST = 7'(TICK_FREQ - 1);
    localparam logic [4:0] HOUR_INIT = 5'(INIT_HOUR);
    localparam logic [4:0] HOUR_LAST = 5'd23;
    localparam logic [5:0] MS_LAST   = 6'd59;

    logic [6:0] csec_d;
    logic [5:0] sec_d;
    logic [5:0] min_d;
    logic [4:0] hour_d;
    logic       sec_pulse_d;
    logic       day_pulse_d;
    logic       load_err_d;

    logic       hour_bad;
    logic       min_bad;
    logic       sec_bad;

    assign hour_bad = (i_set_hour > HOUR_LAST);
    assign min_bad  = (i_set_min  > MS_LAST);
    assign sec_bad  = (i_set_sec  > MS_LAST);

    // Next-state logic. Events are mutually exclusive by priority:
    // clear > load > increments > counted tick. A tick that coincides with
    // any higher-priority event is simply dropped.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        csec_d      = o_csec;
        sec_d       = o_sec;
        min_d       = o_min;
        hour_d      = o_hour;
        sec_pulse_d = 1'b0;
        day_pulse_d = 1'b0;
        load_err_d  = 1'b0;

        if (i_clear) begin
            csec_d = '0;
            sec_d  = '0;
            min_d  = '0;
            hour_d = HOUR_INIT;
        end else if (i_load) begin
            csec_d     = '0;
            hour_d     = hour_bad ? 5'd0 : i_set_hour;
            min_d      = min_bad  ? 6'd0 : i_set_min;
            sec_d      = sec_bad  ? 6'd0 : i_set_sec;
            load_err_d = hour_bad | min_bad | sec_bad;
        end else if (i_inc_hour || i_inc_min) begin
            // Manual setting: each field wraps on its own, no carry.
            if (i_inc_hour) begin
                hour_d = (o_hour == HOUR_LAST) ? 5'd0 : o_hour + 5'd1;
            end
            if (i_inc_min) begin
                min_d = (o_min == MS_LAST) ? 6'd0 : o_min + 6'd1;
            end
        end else if (i_tick && i_run) begin
            // Full ripple resolves in one cycle.
            if (o_csec == CSEC_LAST) begin
                csec_d      = '0;
                sec_pulse_d = 1'b1;
                if (o_sec == MS_LAST) begin
                    sec_d = '0;
                    if (o_min == MS_LAST) begin
                        min_d = '0;
                        if (o_hour == HOUR_LAST) begin
                            hour_d      = '0;
                            day_pulse_d = 1'b1;
                        end else begin
                            hour_d = o_hour + 5'd1;
                        end
                    end else begin
                        min_d = o_min + 6'd1;
                    end
                end else begin
                    sec_d = o_sec + 6'd1;
                end
            end else begin
                csec_d = o_csec + 7'd1;
            end
        end
    end

    // NOTE: reset is sampled on the clock edge (synchronous) and state is
    // updated with non-blocking assignments so all fields change together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_csec      <= '0;
            o_sec       <= '0;
            o_min       <= '0;
            o_hour      <= HOUR_INIT;
            o_sec_pulse <= 1'b0;
            o_day_pulse <= 1'b0;
            o_load_err  <= 1'b0;
        end else begin
            o_csec      <= csec_d;
            o_sec       <= sec_d;
            o_min       <= min_d;
            o_hour      <= hour_d;
            o_sec_pulse <= sec_pulse_d;
            o_day_pulse <= day_pulse_d;
            o_load_err  <= load_err_d;
        end
    end

endmodule

// File: tb/tb_watch_time_counter.sv
// tb_watch_time_counter
// Self-checking bench for watch_time_counter: a table of hand-derived
// vectors, hand-written multi-cycle corner sequences, and a randomized run
// compared against a reference model that tracks time as a single count of
// centiseconds since midnight.
module tb_watch_time_counter;

    localparam int TF      = 100;
    localparam int DAY_CS  = 24 * 60 * 60 * TF;

    logic       clk;
    logic       reset;
    logic       i_tick;
    logic       i_run;
    logic       i_clear;
    logic       i_load;
    logic [4:0] i_set_hour;
    logic [5:0] i_set_min;
    logic [5:0] i_set_sec;
    logic       i_inc_hour;
    logic       i_inc_min;
    logic [6:0] o_csec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_sec_pulse;
    logic       o_day_pulse;
    logic       o_load_err;

    int checks;
    int failures;

    // reference model state
    int m_h, m_m, m_s, m_cs;
    bit m_sp, m_dp, m_err;

    watch_time_counter #(.TICK_FREQ(TF), .INIT_HOUR(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_tick     (i_tick),
        .i_run      (i_run),
        .i_clear    (i_clear),
        .i_load     (i_load),
        .i_set_hour (i_set_hour),
        .i_set_min  (i_set_min),
        .i_set_sec  (i_set_sec),
        .i_inc_hour (i_inc_hour),
        .i_inc_min  (i_inc_min),
        .o_csec     (o_csec),
        .o_sec      (o_sec),
        .o_min      (o_min),
        .o_hour     (o_hour),
        .o_sec_pulse(o_sec_pulse),
        .o_day_pulse(o_day_pulse),
        .o_load_err (o_load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst_n;
        bit clr;
        bit ld;
        int sh;
        int sm;
        int ss;
        bit ih;
        bit im;
        bit tk;
        bit rn;
        int eh;
        int em;
        int es;
        int ecs;
        bit esp;
        bit edp;
        bit eerr;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic drive(input bit r, input bit c, input bit l, input int sh,
                         input int sm, input int ss, input bit ih, input bit im,
                         input bit tk, input bit rn);
        reset      = r;
        i_clear    = c;
        i_load     = l;
        i_set_hour = 5'(sh);
        i_set_min  = 6'(sm);
        i_set_sec  = 6'(ss);
        i_inc_hour = ih;
        i_inc_min  = im;
        i_tick     = tk;
        i_run      = rn;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Behavioural reference: time is one centisecond count within a day.
    task automatic model_step();
        int total;
        m_sp  = 1'b0;
        m_dp  = 1'b0;
        m_err = 1'b0;
        if (!reset || i_clear) begin
            m_h = 12; m_m = 0; m_s = 0; m_cs = 0;
        end else if (i_load) begin
            m_cs  = 0;
            m_h   = (int'(i_set_hour) > 23) ? 0 : int'(i_set_hour);
            m_m   = (int'(i_set_min)  > 59) ? 0 : int'(i_set_min);
            m_s   = (int'(i_set_sec)  > 59) ? 0 : int'(i_set_sec);
            m_err = (int'(i_set_hour) > 23) || (int'(i_set_min) > 59) ||
                    (int'(i_set_sec) > 59);
        end else if (i_inc_hour || i_inc_min) begin
            if (i_inc_hour) m_h = (m_h + 1) % 24;
            if (i_inc_min)  m_m = (m_m + 1) % 60;
        end else if (i_tick && i_run) begin
            total = ((m_h * 60 + m_m) * 60 + m_s) * TF + m_cs + 1;
            m_sp  = (total % TF) == 0;
            if (total == DAY_CS) begin
                m_dp  = 1'b1;
                total = 0;
            end
            m_cs = total % TF;
            m_s  = (total / TF) % 60;
            m_m  = (total / (TF * 60)) % 60;
            m_h  = total / (TF * 3600);
        end
    endtask

    // Advance one clock: model sees the same inputs the DUT samples.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".hour"},  int'(o_hour),      m_h);
        check({tag, ".min"},   int'(o_min),       m_m);
        check({tag, ".sec"},   int'(o_sec),       m_s);
        check({tag, ".csec"},  int'(o_csec),      m_cs);
        check({tag, ".spls"},  int'(o_sec_pulse), int'(m_sp));
        check({tag, ".dpls"},  int'(o_day_pulse), int'(m_dp));
        check({tag, ".lerr"},  int'(o_load_err),  int'(m_err));
    endtask

    task automatic check_time(input string tag, input int h, input int m,
                              input int s, input int cs);
        check({tag, ".hour"}, int'(o_hour), h);
        check({tag, ".min"},  int'(o_min),  m);
        check({tag, ".sec"},  int'(o_sec),  s);
        check({tag, ".csec"}, int'(o_csec), cs);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        idle();
    endtask

    task automatic load(input int h, input int m, input int s);
        drive(1'b1, 1'b0, 1'b1, h, m, s, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle();
    endtask

    initial begin
        int pulses;
        checks   = 0;
        failures = 0;
        m_h = 0; m_m = 0; m_s = 0; m_cs = 0;
        m_sp = 0; m_dp = 0; m_err = 0;
        idle();
        reset = 1'b0;

        // ---------------- reset state ----------------
        do_reset();
        check_time("rst", 12, 0, 0, 0);
        check("rst.spls", int'(o_sec_pulse), 0);
        check("rst.dpls", int'(o_day_pulse), 0);
        check("rst.lerr", int'(o_load_err), 0);

        // ---------------- vector table ----------------
        //          rst clr ld  sh  sm  ss  ih im tk rn   eh em es ecs sp dp err
        tbl[0]  = '{1, 0, 0,  0,  0,  0, 0, 0, 0, 0,  12, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 25, 30, 61, 0, 0, 0, 0,   0,30, 0, 0, 0, 0, 1};
        tbl[2]  = '{1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   0,30, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 1, 10, 20, 30, 0, 0, 0, 0,  10,20,30, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 0,  0,  0,  0, 0, 0, 1, 1,  10,20,30, 1, 0, 0, 0};
        tbl[5]  = '{1, 0, 0,  0,  0,  0, 0, 0, 1, 0,  10,20,30, 1, 0, 0, 0};
        tbl[6]  = '{1, 0, 0,  0,  0,  0, 0, 1, 0, 0,  10,21,30, 1, 0, 0, 0};
        tbl[7]  = '{1, 0, 0,  0,  0,  0, 1, 1, 1, 1,  11,22,30, 1, 0, 0, 0};
        tbl[8]  = '{1, 0, 1, 23, 59, 59, 0, 0, 1, 1,  23,59,59, 0, 0, 0, 0};
        tbl[9]  = '{1, 1, 1,  1,  1,  1, 1, 1, 1, 1,  12, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 1,  5, 59, 59, 0, 0, 0, 0,   5,59,59, 0, 0, 0, 0};
        tbl[11] = '{1, 0, 0,  0,  0,  0, 0, 1, 0, 1,   5, 0,59, 0, 0, 0, 0};
        tbl[12] = '{1, 0, 1, 23,  0, 60, 0, 0, 0, 0,  23, 0, 0, 0, 0, 0, 1};
        tbl[13] = '{1, 0, 0,  0,  0,  0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst_n, tbl[i].clr, tbl[i].ld, tbl[i].sh, tbl[i].sm,
                  tbl[i].ss, tbl[i].ih, tbl[i].im, tbl[i].tk, tbl[i].rn);
            step();
            check_time($sformatf("vec%0d", i), tbl[i].eh, tbl[i].em, tbl[i].es,
                       tbl[i].ecs);
            check($sformatf("vec%0d.spls", i), int'(o_sec_pulse), int'(tbl[i].esp));
            check($sformatf("vec%0d.dpls", i), int'(o_day_pulse), int'(tbl[i].edp));
            check($sformatf("vec%0d.lerr", i), int'(o_load_err),  int'(tbl[i].eerr));
        end
        idle();

        // ---------------- 100 ticks after reset ----------------
        do_reset();
        step();
        check_time("postrst", 12, 0, 0, 0);
        pulses = 0;
        for (int i = 1; i <= 100; i++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
            step();
            check_model("sec");
            if (o_sec_pulse) pulses++;
        end
        idle();
        check("sec.pulse_at_100", int'(o_sec_pulse), 1);
        check("sec.pulse_count", pulses, 1);
        check_time("sec.final", 12, 0, 1, 0);
        step();
        check("sec.pulse_drop", int'(o_sec_pulse), 0);

        // ---------------- day rollover ----------------
        load(23, 59, 59);
        for (int i = 1; i <= 100; i++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
            step();
            check_model("day");
        end
        idle();
        check_time("day.final", 0, 0, 0, 0);
        check("day.spls", int'(o_sec_pulse), 1);
        check("day.dpls", int'(o_day_pulse), 1);

        // ---------------- increments beat a coincident tick ----------------
        load(23, 59, 10);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
            step();
        end
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        idle();
        check_time("inc", 0, 0, 10, 5);
        check("inc.dpls", int'(o_day_pulse), 0);

        // ---------------- run=0 holds, then clear ----------------
        load(5, 6, 7);
        for (int i = 0; i < 42; i++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
            step();
        end
        for (int i = 0; i < 500; i++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
            step();
            if (o_sec_pulse) check("hold.spls", int'(o_sec_pulse), 0);
        end
        check_time("hold", 5, 6, 7, 42);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        check_time("clr", 12, 0, 0, 0);

        // ---------------- reset mid-ripple ----------------
        load(23, 59, 59);
        for (int i = 0; i < 99; i++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
            step();
        end
        check_time("pre_rst", 23, 59, 59, 99);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        check_time("rst_ripple", 12, 0, 0, 0);
        check("rst_ripple.dpls", int'(o_day_pulse), 0);
        check("rst_ripple.spls", int'(o_sec_pulse), 0);

        // ---------------- randomized run against the model ----------------
        for (int i = 0; i < 20000; i++) begin
            drive($urandom_range(0, 499) != 0,
                  $urandom_range(0, 299) == 0,
                  $urandom_range(0, 149) == 0,
                  ($urandom_range(0, 1) != 0) ? 23 : int'($urandom_range(0, 31)),
                  ($urandom_range(0, 1) != 0) ? 59 : int'($urandom_range(0, 63)),
                  ($urandom_range(0, 1) != 0) ? 59 : int'($urandom_range(0, 63)),
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) != 0,
                  $urandom_range(0, 7) != 0);
            step();
            check_model("rand");
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
